// File: rtl/board_pkg.sv
// Shared types and constants for the tile board: geometry, request record,
// FSM encoding and the row/column to RAM address mapping.
package board_pkg;

  localparam int BOARD_COLS       = 40;
  localparam int BOARD_ROWS       = 30;
  localparam int BOARD_FIFO_DEPTH = 4;
  localparam int ADDR_W           = 11;
  localparam int TILE_W           = 8;
  localparam int POS_W            = 6;
  localparam int REQ_W            = ADDR_W + TILE_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [TILE_W-1:0] tile_t;

  typedef struct packed {
    addr_t addr;
    tile_t sprite;
  } req_t;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_LOOKUP,
    ST_RESP
  } state_t;

  // For the 40-wide board row*40 is folded into two shifts and an add.
  function automatic addr_t tile_addr(input logic [POS_W-1:0] row,
                                      input logic [POS_W-1:0] col,
                                      input int cols);
    addr_t r;
    addr_t c;
    r = addr_t'(row);
    c = addr_t'(col);
    if (cols == 40) return (r << 5) + (r << 3) + c;
    return (r * addr_t'(cols)) + c;
  endfunction

endpackage

// File: rtl/tile_req_fifo.sv
// Write-request buffer: synchronous FIFO of {addr, sprite} records. A push
// into a full FIFO is still taken when a pop happens in the same cycle.
module tile_req_fifo
  import board_pkg::*;
#(
  parameter int DEPTH = BOARD_FIFO_DEPTH
) (
  input  logic             px_clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [REQ_W-1:0] din,
  output logic [REQ_W-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             single
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [REQ_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign single  = (count == (PTR_W+1)'(1));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge px_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge px_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tile_board.sv
// Tile-map store for the 40x30 board: buffers game-logic writes, serves the
// renderer at fixed latency and answers get lookups. Optional power-up RAM
// clear is built when TILE_BOARD_CLEAR_EN is defined.
module tile_board
  import board_pkg::*;
#(
  parameter int COLS       = BOARD_COLS,
  parameter int ROWS       = BOARD_ROWS,
  parameter int FIFO_DEPTH = BOARD_FIFO_DEPTH
) (
  input  logic       px_clk,
  input  logic       rst,
  input  logic       update,
  input  logic [5:0] posx,
  input  logic [5:0] posy,
  input  logic [7:0] sprite,
  input  logic       get,
  output logic [7:0] read_sprite,
  output logic       read_valid,
  input  logic       rd_en,
  input  logic [5:0] rd_col,
  input  logic [4:0] rd_row,
  output logic [7:0] rd_tile,
  output logic       busy,
  output logic       overflow,
  output logic       err_range
);

  localparam int CELLS = COLS * ROWS;

  state_t state;
  state_t state_next;
  logic   update_q;
  logic   get_q;
  logic   upd_edge;
  logic   get_edge;
  logic   pos_ok;
  logic   rd_ok;
  addr_t  pos_addr;
  addr_t  rd_addr;
  addr_t  get_addr;
  addr_t  ram_addr;
  addr_t  clr_addr;
  tile_t  mem [CELLS];
  tile_t  ram_rdata;
  tile_t  ram_wdata;
  logic   ram_we;
  logic   lookup_rd;
  req_t   push_req;
  req_t   head;
  logic   fifo_push;
  logic   fifo_pop;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_single;
  logic   push_ok;
  logic   get_pending;
  logic   get_active;
  logic   get_accept;
  logic   get_bad;
  logic   get_want;

  assign upd_edge = update & ~update_q;
  assign get_edge = get & ~get_q;
  assign pos_ok   = (int'(posx) < COLS) && (int'(posy) < ROWS);
  assign rd_ok    = (int'(rd_col) < COLS) && (int'(rd_row) < ROWS);
  assign pos_addr = tile_addr(posy, posx, COLS);
  assign rd_addr  = tile_addr({1'b0, rd_row}, rd_col, COLS);

  assign push_req  = '{addr: pos_addr, sprite: sprite};
  assign fifo_push = upd_edge & pos_ok;
  assign push_ok   = fifo_push & (~fifo_full | fifo_pop);

  // Only one get in flight; edges arriving while one is outstanding are ignored.
  assign get_active = get_pending | (state == ST_LOOKUP) | (state == ST_RESP);
  assign get_accept = get_edge & pos_ok & ~get_active;
  assign get_bad    = get_edge & ~pos_ok & ~get_active;
  assign get_want   = get_pending | get_accept;

  assign busy = ~fifo_empty | get_active | (state == ST_CLEAR);

  tile_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .px_clk (px_clk),
    .rst    (rst),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (push_req),
    .dout   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .single (fifo_single)
  );

  always_ff @(posedge px_clk) begin
    if (rst) begin
`ifdef TILE_BOARD_CLEAR_EN
      state <= ST_CLEAR;
`else
      state <= ST_IDLE;
`endif
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next defaults to state so every path assigns it and no latch forms.
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR:  if (!rd_en && clr_addr == addr_t'(CELLS - 1)) state_next = ST_IDLE;
      ST_IDLE: begin
        if (!rd_en) begin
          if (!fifo_empty)              state_next = ST_WRITE;
          else if (get_want && !push_ok) state_next = ST_LOOKUP;
        end
      end
      // Back-to-back entries drain without returning to IDLE.
      ST_WRITE:  if (!rd_en && fifo_single && !push_ok) state_next = ST_IDLE;
      ST_LOOKUP: if (!rd_en) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_pop  = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    lookup_rd = 1'b0;
    ram_addr  = get_addr;
    if (rd_en) begin
      ram_addr = rd_addr;
    end else begin
      case (state)
        ST_WRITE: begin
          fifo_pop  = 1'b1;
          ram_we    = 1'b1;
          ram_wdata = head.sprite;
          ram_addr  = head.addr;
        end
        ST_CLEAR: begin
          ram_we   = 1'b1;
          ram_addr = clr_addr;
        end
        ST_LOOKUP: lookup_rd = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef TILE_BOARD_CLEAR_EN
  always_ff @(posedge px_clk) begin
    if (rst)                                clr_addr <= '0;
    else if (state == ST_CLEAR && !rd_en)   clr_addr <= clr_addr + addr_t'(1);
  end
`else
  assign clr_addr = '0;
`endif

  always_ff @(posedge px_clk) begin
    if (ram_we && !rst) mem[ram_addr] <= ram_wdata;
    if (lookup_rd)      ram_rdata     <= mem[ram_addr];
  end

  always_ff @(posedge px_clk) begin
    if (rst)        rd_tile <= '0;
    else if (rd_en) rd_tile <= rd_ok ? mem[ram_addr] : '0;
  end

  always_ff @(posedge px_clk) begin
    if (rst) begin
      update_q    <= 1'b0;
      get_q       <= 1'b0;
      get_pending <= 1'b0;
      get_addr    <= '0;
      overflow    <= 1'b0;
      err_range   <= 1'b0;
      read_valid  <= 1'b0;
      read_sprite <= '0;
    end else begin
      update_q <= update;
      get_q    <= get;
      if (get_accept) begin
        get_pending <= 1'b1;
        get_addr    <= pos_addr;
      end else if (state == ST_LOOKUP) begin
        get_pending <= 1'b0;
      end
      if (fifo_push && fifo_full && !fifo_pop) overflow  <= 1'b1;
      if ((upd_edge || get_edge) && !pos_ok)   err_range <= 1'b1;
      read_valid <= 1'b0;
      if (state == ST_RESP) begin
        read_valid  <= 1'b1;
        read_sprite <= ram_rdata;
      end else if (get_bad) begin
        read_valid  <= 1'b1;
        read_sprite <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_board.sv
// Directed bench for tile_board: table of writes read back through both
// readers, plus hand sequences for timing, stall, overflow, range and reset.
module tb_tile_board;

  logic       px_clk = 1'b0;
  logic       rst;
  logic       update;
  logic [5:0] posx;
  logic [5:0] posy;
  logic [7:0] sprite;
  logic       get;
  logic [7:0] read_sprite;
  logic       read_valid;
  logic       rd_en;
  logic [5:0] rd_col;
  logic [4:0] rd_row;
  logic [7:0] rd_tile;
  logic       busy;
  logic       overflow;
  logic       err_range;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 px_clk = ~px_clk;

  tile_board dut (
    .px_clk      (px_clk),
    .rst         (rst),
    .update      (update),
    .posx        (posx),
    .posy        (posy),
    .sprite      (sprite),
    .get         (get),
    .read_sprite (read_sprite),
    .read_valid  (read_valid),
    .rd_en       (rd_en),
    .rd_col      (rd_col),
    .rd_row      (rd_row),
    .rd_tile     (rd_tile),
    .busy        (busy),
    .overflow    (overflow),
    .err_range   (err_range)
  );

  typedef struct {
    logic [5:0] x;
    logic [5:0] y;
    logic [7:0] s;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge px_clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input int x, input int y, input logic [7:0] s);
    posx   = 6'(x);
    posy   = 6'(y);
    sprite = s;
    update = 1'b1;
    tick();
    update = 1'b0;
    tick();
  endtask

  task automatic do_get(input int x, input int y, output logic [7:0] d, output logic ok);
    ok   = 1'b0;
    d    = '0;
    posx = 6'(x);
    posy = 6'(y);
    get  = 1'b1;
    tick();
    get  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (read_valid) begin
        d  = read_sprite;
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic rd_read(input int x, input int y, output logic [7:0] d);
    rd_en  = 1'b1;
    rd_col = 6'(x);
    rd_row = 5'(y);
    tick();
    rd_en  = 1'b0;
    d      = rd_tile;
  endtask

  task automatic wait_idle(input string name, input int limit = 60);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      tick();
    end
    check(name, busy, 1'b0);
  endtask

  task automatic get_check(input string name, input int x, input int y, input logic [7:0] exp);
    logic [7:0] d;
    logic       ok;
    do_get(x, y, d, ok);
    check({name, "_valid"}, ok, 1'b1);
    check(name, d, exp);
  endtask

  task automatic rd_check(input string name, input int x, input int y, input logic [7:0] exp);
    logic [7:0] d;
    rd_read(x, y, d);
    check(name, d, exp);
  endtask

  initial begin
    int n;

    rst = 1'b1; update = 1'b0; get = 1'b0; rd_en = 1'b0;
    posx = '0; posy = '0; sprite = '0; rd_col = '0; rd_row = '0;
    tick(3);
    check("rst_read_sprite", read_sprite, 8'h00);
    check("rst_read_valid", read_valid, 1'b0);
    check("rst_rd_tile", rd_tile, 8'h00);
    check("rst_overflow", overflow, 1'b0);
    check("rst_err_range", err_range, 1'b0);
`ifdef TILE_BOARD_CLEAR_EN
    check("rst_busy", busy, 1'b1);
    rst = 1'b0;
    n = 0;
    while (busy && n < 1500) begin tick(); n++; end
    check("clear_cycles", n, 1200);
    get_check("clear_corner", 39, 29, 8'h00);
    tick(497);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("clear_restart_busy", busy, 1'b1);
    n = 0;
    while (busy && n < 1500) begin tick(); n++; end
    check("clear_restart_cycles", n, 1200);
`else
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
`endif

    // Write (3,4) then renderer read at the earliest cycle the value is committed.
    posx = 6'd3; posy = 6'd4; sprite = 8'h27; update = 1'b1;
    tick();
    update = 1'b0;
    tick(2);
    rd_en = 1'b1; rd_col = 6'd3; rd_row = 5'd4;
    tick();
    rd_en = 1'b0; rd_col = 6'd0; rd_row = 5'd0;
    check("wr_latency_rd_tile", rd_tile, 8'h27);
    tick();
    check("rd_tile_hold", rd_tile, 8'h27);
    check("wr_idle_busy", busy, 1'b0);

    // Get latency: edge at N, read_valid exactly at N+3 for one cycle.
    posx = 6'd3; posy = 6'd4; get = 1'b1;
    tick();
    get = 1'b0;
    check("get_n1_valid", read_valid, 1'b0);
    check("get_n1_busy", busy, 1'b1);
    tick();
    check("get_n2_valid", read_valid, 1'b0);
    tick();
    check("get_n3_valid", read_valid, 1'b1);
    check("get_n3_sprite", read_sprite, 8'h27);
    tick();
    check("get_n4_valid", read_valid, 1'b0);

    vecs[0] = '{x: 6'd0,  y: 6'd0,  s: 8'h01, exp: 8'h01};
    vecs[1] = '{x: 6'd39, y: 6'd29, s: 8'hFF, exp: 8'hFF};
    vecs[2] = '{x: 6'd39, y: 6'd0,  s: 8'h80, exp: 8'h80};
    vecs[3] = '{x: 6'd0,  y: 6'd29, s: 8'h7E, exp: 8'h7E};
    vecs[4] = '{x: 6'd10, y: 6'd2,  s: 8'h11, exp: 8'h11};
    vecs[5] = '{x: 6'd20, y: 6'd15, s: 8'hA5, exp: 8'hA5};
    vecs[6] = '{x: 6'd1,  y: 6'd1,  s: 8'h3C, exp: 8'h3C};
    vecs[7] = '{x: 6'd0,  y: 6'd4,  s: 8'h66, exp: 8'h66};
    vecs[8] = '{x: 6'd7,  y: 6'd4,  s: 8'hA0, exp: 8'hA0};
    vecs[9] = '{x: 6'd7,  y: 6'd5,  s: 8'hA0, exp: 8'hA0};

    foreach (vecs[i]) do_write(int'(vecs[i].x), int'(vecs[i].y), vecs[i].s);
    wait_idle("table_idle");
    foreach (vecs[i]) begin
      get_check($sformatf("table_get%0d", i), int'(vecs[i].x), int'(vecs[i].y), vecs[i].exp);
      rd_check($sformatf("table_rd%0d", i), int'(vecs[i].x), int'(vecs[i].y), vecs[i].exp);
    end

    // Same-cycle update and get: the get must see the new value.
    posx = 6'd10; posy = 6'd2; sprite = 8'h55; update = 1'b1; get = 1'b1;
    tick();
    update = 1'b0; get = 1'b0;
    n = 0;
    while (!read_valid && n < 40) begin tick(); n++; end
    check("same_cycle_valid", read_valid, 1'b1);
    check("same_cycle_sprite", read_sprite, 8'h55);
    tick();

    // Renderer stall: 4 queued writes held off for 20 cycles, then drained back to back.
    do_write(5, 5, 8'h5A);
    wait_idle("stall_pre_idle");
    rd_en = 1'b1; rd_col = 6'd5; rd_row = 5'd5;
    for (int i = 0; i < 4; i++) do_write(5, 5 + i, 8'hC0 + 8'(i));
    tick(12);
    check("stall_no_write", rd_tile, 8'h5A);
    check("stall_busy", busy, 1'b1);
    check("stall_no_overflow", overflow, 1'b0);
    rd_en = 1'b0;
    tick(4);
    check("drain_busy_4", busy, 1'b1);
    tick();
    check("drain_busy_5", busy, 1'b0);
    for (int i = 0; i < 4; i++) rd_check($sformatf("drain_rd%0d", i), 5, 5 + i, 8'hC0 + 8'(i));

    // Full FIFO with a pop in the same cycle still accepts the push.
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) do_write(6, i, 8'hD0 + 8'(i));
    rd_en = 1'b0;
    tick();
    posx = 6'd6; posy = 6'd4; sprite = 8'hD4; update = 1'b1;
    tick();
    update = 1'b0;
    wait_idle("fullpop_idle");
    check("fullpop_overflow", overflow, 1'b0);
    rd_check("fullpop_first", 6, 0, 8'hD0);
    get_check("fullpop_last", 6, 4, 8'hD4);

    // Overflow: 6 requests into a 4-deep FIFO while the renderer blocks.
    rd_en = 1'b1;
    for (int i = 0; i < 6; i++) do_write(7, i, 8'hE0 + 8'(i));
    check("ovf_flag", overflow, 1'b1);
    check("ovf_busy", busy, 1'b1);
    rd_en = 1'b0;
    wait_idle("ovf_idle");
    for (int i = 0; i < 4; i++) rd_check($sformatf("ovf_kept%0d", i), 7, i, 8'hE0 + 8'(i));
    rd_check("ovf_drop4", 7, 4, 8'hA0);
    rd_check("ovf_drop5", 7, 5, 8'hA0);
    check("ovf_sticky", overflow, 1'b1);

    // Out-of-range requests.
    check("range_clear", err_range, 1'b0);
    do_write(40, 3, 8'hEE);
    check("range_col_err", err_range, 1'b1);
    check("range_col_busy", busy, 1'b0);
    do_write(0, 30, 8'hEE);
    wait_idle("range_idle");
    get_check("range_ram_kept", 0, 4, 8'h66);
    posx = 6'd45; posy = 6'd0; get = 1'b1;
    tick();
    get = 1'b0;
    check("range_get_valid", read_valid, 1'b1);
    check("range_get_sprite", read_sprite, 8'h00);
    tick();
    check("range_get_pulse", read_valid, 1'b0);

    // Reset mid-operation: queued writes and pending get are dropped.
    rd_en = 1'b1; rd_col = 6'd0; rd_row = 5'd0;
    do_write(1, 1, 8'h77);
    do_write(20, 15, 8'h77);
    posx = 6'd3; posy = 6'd4; get = 1'b1;
    tick();
    get = 1'b0;
    rst = 1'b1;
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_err_range", err_range, 1'b0);
    check("midrst_valid", read_valid, 1'b0);
`ifdef TILE_BOARD_CLEAR_EN
    check("midrst_busy", busy, 1'b1);
    wait_idle("midrst_clear_idle", 1300);
    rd_check("midrst_cleared", 1, 1, 8'h00);
`else
    check("midrst_busy", busy, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (read_valid) n++;
      tick();
    end
    check("midrst_no_resp", n, 0);
    rd_check("midrst_ram_kept0", 1, 1, 8'h3C);
    rd_check("midrst_ram_kept1", 20, 15, 8'hA5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
